// File: rtl/cmd_parse_pkg.sv
// Shared definitions for the command frame parser: opcodes, per-opcode length table,
// CRC constants and FSM state encoding.
package cmd_parse_pkg;

  localparam logic [7:0]  OP_SORT     = 8'h00;
  localparam logic [7:0]  OP_QUERY    = 8'h01;
  localparam logic [7:0]  OP_READ     = 8'h02;
  localparam logic [7:0]  OP_WRITE    = 8'h03;

  localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;
  localparam logic [15:0] CRC_POLY    = 16'h1021;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_CHECK,
    ST_REPORT
  } state_t;

  typedef struct packed {
    logic       known;
    logic       var_len;
    logic [6:0] len;
    logic       mem;
  } cmd_info_t;

  // For variable-length opcodes, len is the minimum payload size.
  function automatic cmd_info_t cmd_info(input logic [7:0] op);
    cmd_info_t info;
    info = '{known: 1'b0, var_len: 1'b0, len: 7'd0, mem: 1'b0};
    case (op)
      OP_SORT:  info = '{known: 1'b1, var_len: 1'b1, len: 7'd16, mem: 1'b0};
      OP_QUERY: info = '{known: 1'b1, var_len: 1'b0, len: 7'd16, mem: 1'b0};
      OP_READ:  info = '{known: 1'b1, var_len: 1'b0, len: 7'd32, mem: 1'b1};
      OP_WRITE: info = '{known: 1'b1, var_len: 1'b0, len: 7'd48, mem: 1'b1};
      default:  ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16/CCITT (poly 0x1021), MSB first. init presets the register and,
// when bit_vld is also high, folds that bit in on the same cycle.
module crc16_serial
  import cmd_parse_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        bit_vld,
  input  logic        bit_data,
  output logic [15:0] crc
);

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC_POLY : 16'h0000);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 16'h0000;
    end else if (init) begin
      crc <= bit_vld ? crc_step(CRC_PRESET, bit_data) : CRC_PRESET;
    end else if (bit_vld) begin
      crc <= crc_step(crc, bit_data);
    end
  end

endmodule

// File: rtl/cmd_parse.sv
// Command frame parser: head / payload / CRC-16 assembly and frame check.
// Define CMD_CRC_CHECK_EN to include the CRC residue check.
//   state     | meaning
//   ST_IDLE   | waiting for the first bit of a frame
//   ST_HEAD   | shifting in the 8-bit opcode
//   ST_BODY   | shifting payload + CRC field
//   ST_CHECK  | one-cycle frame evaluation
//   ST_REPORT | result pulse is on the outputs
module cmd_parse
  import cmd_parse_pkg::*;
#(
  parameter int PAYLOAD_W = 64
) (
  input  logic                 DOUB_BLF,
  input  logic                 rst,
  input  logic                 dec_en,
  input  logic                 bit_vld,
  input  logic                 bit_data,
  input  logic                 frame_end,
  output logic                 new_cmd,
  output logic [7:0]           cmd_head,
  output logic [PAYLOAD_W-1:0] cmd_param,
  output logic [6:0]           param_len,
  output logic                 parse_done,
  output logic                 parse_err,
  output logic                 parse_iereq
);

  localparam int BODY_W = PAYLOAD_W + 16;

  state_t              r_state;
  logic [6:0]          r_head_sr;
  logic [2:0]          r_hcnt;
  logic [BODY_W-1:0]   r_body;
  logic [7:0]          r_bcnt;
  logic                r_ovf;

  cmd_info_t           w_info;
  logic [7:0]          w_need;
  logic                w_len_ok;
  logic                w_crc_ok;
  logic                w_pass;

`ifdef CMD_CRC_CHECK_EN
  logic [15:0] w_crc;
  logic        w_crc_init;
  logic        w_crc_vld;

  // Leaving dec_en low holds the CRC at its preset.
  assign w_crc_init = !dec_en || (r_state == ST_IDLE && bit_vld);
  assign w_crc_vld  = dec_en && bit_vld &&
                      (r_state == ST_IDLE || r_state == ST_HEAD || r_state == ST_BODY);

  crc16_serial u_crc (
    .clk      (DOUB_BLF),
    .rst      (rst),
    .init     (w_crc_init),
    .bit_vld  (w_crc_vld),
    .bit_data (bit_data),
    .crc      (w_crc)
  );

  assign w_crc_ok = (w_crc == CRC_RESIDUE);
`else
  assign w_crc_ok = 1'b1;
`endif

  // A frame that ended in HEAD has a body count of 0 and fails the length test.
  assign w_info   = cmd_info(cmd_head);
  assign w_need   = 8'd16 + {1'b0, w_info.len};
  assign w_len_ok = w_info.var_len ? (r_bcnt >= w_need) : (r_bcnt == w_need);
  assign w_pass   = (r_bcnt >= 8'd16) && w_info.known && w_len_ok && !r_ovf && w_crc_ok;

  always_ff @(posedge DOUB_BLF or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_head_sr   <= '0;
      r_hcnt      <= '0;
      r_body      <= '0;
      r_bcnt      <= '0;
      r_ovf       <= 1'b0;
      new_cmd     <= 1'b0;
      cmd_head    <= '0;
      cmd_param   <= '0;
      param_len   <= '0;
      parse_done  <= 1'b0;
      parse_err   <= 1'b0;
      parse_iereq <= 1'b0;
    end else begin
      new_cmd     <= 1'b0;
      parse_done  <= 1'b0;
      parse_err   <= 1'b0;
      parse_iereq <= 1'b0;
      if (!dec_en) begin
        r_state <= ST_IDLE;
        r_hcnt  <= '0;
        r_bcnt  <= '0;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bit_vld) begin
              r_state   <= ST_HEAD;
              r_head_sr <= {6'd0, bit_data};
              r_hcnt    <= 3'd1;
              r_body    <= '0;
              r_bcnt    <= '0;
              r_ovf     <= 1'b0;
              new_cmd   <= 1'b1;
            end
          end
          ST_HEAD: begin
            if (bit_vld) begin
              r_head_sr <= {r_head_sr[5:0], bit_data};
              r_hcnt    <= r_hcnt + 3'd1;
              if (r_hcnt == 3'd7) begin
                cmd_head <= {r_head_sr, bit_data};
                r_state  <= ST_BODY;
              end
            end
            if (frame_end) r_state <= ST_CHECK;
          end
          ST_BODY: begin
            if (bit_vld) begin
              r_body <= {r_body[BODY_W-2:0], bit_data};
              if (r_bcnt != 8'hFF) r_bcnt <= r_bcnt + 8'd1;
              if (r_bcnt >= 8'(BODY_W)) r_ovf <= 1'b1;
            end
            if (frame_end) r_state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (w_pass) begin
              cmd_param   <= r_body[BODY_W-1:16];
              param_len   <= 7'(r_bcnt - 8'd16);
              parse_done  <= 1'b1;
              parse_iereq <= w_info.mem;
            end else begin
              parse_err   <= 1'b1;
            end
            r_state <= ST_REPORT;
          end
          ST_REPORT: r_state <= ST_IDLE;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
